// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// A mult/multu/div/divu latches its operands on start and holds busy for a fixed
// number of cycles; HI/LO are written on the last busy edge. mthi/mtlo write
// HI/LO directly while idle, and mfhi/mflo read them combinationally.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;

    logic               is_md_start;
    logic               is_mult_op;
    logic [63:0]        prod;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        num;
    logic [31:0]        den;
    logic [31:0]        den_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_we;

    assign is_md_start = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_mult_op  = (md_op == OP_MULT) || (md_op == OP_MULTU);

    // Result datapath, driven only by the latched operands and opcode.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        res_we     = 1'b0;
        // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
        prod       = (op_q == OP_MULT) ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                                       : ({32'd0, a_q} * {32'd0, b_q});
        // Signed division runs on magnitudes so 0x80000000 / -1 cannot overflow the divider.
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed && a_q[31];
        b_neg      = div_signed && b_q[31];
        num        = a_neg ? (32'd0 - a_q) : a_q;
        den        = b_neg ? (32'd0 - b_q) : b_q;
        den_safe   = (den == 32'd0) ? 32'd1 : den;
        q_mag      = num / den_safe;
        r_mag      = num % den_safe;
        quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = a_neg ? (32'd0 - r_mag) : r_mag;
        case (op_q)
            OP_MULT, OP_MULTU: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_we = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_hi = rem;
                res_lo = quot;
                res_we = (b_q != 32'd0);
            end
            default: begin
                res_we = 1'b0;
            end
        endcase
    end

    // Control FSM with registered busy, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            case (state)
                IDLE: begin
                    if (is_md_start) begin
                        op_q  <= md_op;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= is_mult_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (md_op == OP_MTHI) begin
                        HI <= A;
                    end else if (md_op == OP_MTLO) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (res_we) begin
                            HI <= res_hi;
                            LO <= res_lo;
                        end
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // mfhi/mflo read port; no hazard handling, the pipeline stalls around busy.
    always_comb begin
        md_out = 32'd0;
        if (md_op == OP_MFHI) begin
            md_out = HI;
        end else if (md_op == OP_MFLO) begin
            md_out = LO;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed vectors plus random ops, checked through a
// scoreboard of expected HI/LO/busy-length entries popped when busy falls.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    int          bcnt     = 0;
    logic        prev_busy = 1'b0;
    logic [31:0] hi_m     = 32'd0;
    logic [31:0] lo_m     = 32'd0;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .md_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: 64-bit arithmetic, SV truncating division semantics.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa = longint'($signed(a));
        longint          sb_ = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          p;
        longint          q;
        longint          r;
        longint unsigned pu;
        longint unsigned qu;
        longint unsigned ru;
        case (op)
            4'd1: begin p = sa * sb_; return p; end
            4'd2: begin pu = ua * ub; return pu; end
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {hi, lo};
                qu = ua / ub;
                ru = ua % ub;
                return {ru[31:0], qu[31:0]};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Drive a one-cycle start (called at posedge+1) and push its expected outcome.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.n  = (op <= 4'd2) ? MULT_N : DIV_N;
        sb.push_back(e);
        hi_m  = ehi;
        lo_m  = elo;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        md_op = 4'd0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: count busy cycles and check results in the cycle busy falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
            bcnt      = 0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("busy_len", 32'(bcnt), 32'(e.n));
                    check("res_hi", HI, e.hi);
                    check("res_lo", LO, e.lo);
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b1;
        start = 1'b0;
        md_op = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_md_out", md_out, 32'd0);

        // Release reset and start on the very first edge.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        wait_done(40);

        // mfhi/mflo read port.
        md_op = 4'd5; #1 check("mfhi", md_out, 32'hFFFF_FFFF);
        md_op = 4'd6; #1 check("mflo", md_out, 32'hFFFF_FFF1);
        md_op = 4'd0; #1 check("md_none", md_out, 32'd0);
        md_op = 4'd12; #1 check("md_op12", md_out, 32'd0);
        md_op = 4'd0;
        @(posedge clk);
        #1;

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        wait_done(40);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done(40);

        // mthi then divu by zero: HI keeps the mthi value, LO unchanged.
        md_op = 4'd7;
        A     = 32'h1234_5678;
        @(posedge clk);
        #1;
        md_op = 4'd0;
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(4'd4, 32'd7, 32'd0, 32'h1234_5678, 32'hFFFF_FFFD);
        wait_done(40);

        // divu 100/7 with operand changes, a stray start and mtlo/mthi mid-run.
        old_hi = HI;
        issue(4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        @(posedge clk); #1;
        start = 1'b1; md_op = 4'd1; A = $urandom; B = $urandom;
        @(posedge clk); #1;
        start = 1'b0; md_op = 4'd8; A = 32'h0000_DEAD;
        @(posedge clk); #1;
        md_op = 4'd7; A = 32'h0000_BEEF;
        @(posedge clk); #1;
        md_op = 4'd5;
        #1 check("mfhi_in_run", md_out, old_hi);
        md_op = 4'd0;
        wait_done(40);

        // Signed overflow case.
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        wait_done(40);

        // mtlo in idle, and a start with a non-md opcode is ignored.
        md_op = 4'd8;
        A     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        check("mtlo_lo", LO, 32'hCAFE_F00D);
        lo_m  = 32'hCAFE_F00D;
        start = 1'b1;
        md_op = 4'd5;
        @(posedge clk);
        #1;
        check("bad_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        md_op = 4'd0;
        @(posedge clk);
        #1;
        check("bad_start_busy2", 32'(busy), 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 3 == 1) ra = -ra;
            r = model(rop, ra, rb, hi_m, lo_m);
            issue(rop, ra, rb, r[63:32], r[31:0]);
            wait_done(40);
        end

        // Reset pulse in cycle 4 of a div aborts it; HI/LO stay 0 through cycle 15.
        issue(4'd3, 32'd1000, 32'd3, 32'd1, 32'd333);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        sb.delete();
        hi_m = 32'd0;
        lo_m = 32'd0;
        #3 rst_n = 1'b1;
        for (int c = 5; c <= 15; c++) begin
            @(negedge clk);
            check("post_abort_busy", 32'(busy), 32'd0);
            check("post_abort_hi", HI, 32'd0);
            check("post_abort_lo", LO, 32'd0);
        end
        @(posedge clk);
        #1;

        // Unit still works after the abort.
        issue(4'd1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        wait_done(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
